full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- Registered N-bit binary adder with carry-in and carry-out, built as a ripple chain of 1-bit full-adder cells.
- Serves as the basic add primitive of the accelerator datapath; MAC and accumulator stages instantiate it.
- With WIDTH=1 it is the classic 1-bit full adder, with outputs registered one clock after the inputs are sampled.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  qualifies a, b, carry_in on the current rising edge
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- carry_in  input  1  carry into bit 0
- sum  output  WIDTH  registered (a + b + carry_in) modulo 2^WIDTH
- carry_out  output  1  registered carry out of bit WIDTH-1
- out_valid  output  1  high for exactly the cycle after an accepted in_valid

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset: on rst=1, sum=0, carry_out=0, out_valid=0 immediately, without waiting for a clock edge. They hold these values while rst=1.
- Arithmetic:
  - {carry_out, sum} = a + b + carry_in, computed at WIDTH+1 bits.
  - Per bit i: s_i = a_i ^ b_i ^ c_i; c_(i+1) = a_i&b_i | a_i&c_i | b_i&c_i; c_0 = carry_in.
- Latency: 1 cycle. Operands sampled at rising edge k with in_valid=1 appear on sum/carry_out after edge k, with out_valid=1 in that cycle.
- in_valid=0 at an edge:
  - sum and carry_out hold their previous values.
  - out_valid=0.
- Back-to-back: in_valid may be high every cycle. Throughput is one result per cycle and there is no backpressure.
- Boundaries:
  - All-ones + all-ones + 1 gives sum = all-ones, carry_out = 1.
  - All-ones + 0 + 1 wraps: sum = 0, carry_out = 1.
  - 0 + 0 + 0 gives sum = 0, carry_out = 0.
- Reset mid-operation: an asserted rst discards any in-flight result, and out_valid drops at once.
- Release: the first edge with rst=0 and in_valid=1 produces a normal result one cycle later.
- No X propagation requirements beyond standard synthesizable RTL. The output registers are the only state; there is no FSM.

Decomposition:
- Package adder_pkg:
  - ADDER_MAX_WIDTH = 64.
  - Default-width constant ADDER_DEFAULT_WIDTH = 1.
- Sub-module fa_cell: purely combinational 1-bit full adder.
  - Ports a, b, carry_in, sum, carry_out.
  - Instantiated WIDTH times in a generate loop forming the ripple chain.
- full_adder adds the output and valid registers around the chain.

Test Plan:
- WIDTH=1 exhaustive: drive all 8 (a,b,carry_in) combos with in_valid=1, 10 ns apart. Each response is checked one cycle later:
  - 000->s0 c0; 001->s1 c0; 100->s1 c0; 101->s0 c1
  - 010->s1 c0; 011->s0 c1; 110->s0 c1; 111->s1 c1
- Reset: assert rst asynchronously between edges while sum=1, carry_out=1 -> both outputs and out_valid go to 0 before the next edge. They stay 0 until an accepted input after release.
- WIDTH=8 wrap: a=0xFF, b=0x01, carry_in=0 -> sum=0x00, carry_out=1. Then a=0xFF, b=0xFF, carry_in=1 -> sum=0xFF, carry_out=1.
- WIDTH=8 streaming: issue 5 consecutive random operand sets with in_valid=1 -> 5 consecutive out_valid cycles, each matching the reference model delayed by 1 cycle.
- Hold: a valid result, then in_valid=0 with changing operands for 3 cycles -> sum/carry_out unchanged and out_valid=0.
- Reset mid-stream: assert rst one cycle after an accepted input -> no out_valid pulse for that input. The first post-reset input yields a correct result.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants for the datapath adder primitive and its users.
package adder_pkg;

  localparam int ADDER_MAX_WIDTH     = 64;
  localparam int ADDER_DEFAULT_WIDTH = 1;

endpackage : adder_pkg

// File: rtl/fa_cell.sv
// One bit of the ripple chain: a purely combinational 1-bit full adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule : fa_cell

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder with carry-in/out and a one-cycle valid strobe.
module full_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             out_valid
);

  // Keep WIDTH inside the range the accelerator datapath is built for.
  localparam int EFF_WIDTH = (WIDTH > ADDER_MAX_WIDTH) ? ADDER_MAX_WIDTH : WIDTH;

  logic [EFF_WIDTH:0]   carry;
  logic [EFF_WIDTH-1:0] sum_comb;

  assign carry[0] = carry_in;

  for (genvar i = 0; i < EFF_WIDTH; i++) begin : g_chain
    fa_cell u_cell (
      .a         (a[i]),
      .b         (b[i]),
      .carry_in  (carry[i]),
      .sum       (sum_comb[i]),
      .carry_out (carry[i+1])
    );
  end

  // NOTE: registers are written with <= so every flop samples the pre-edge
  // values; blocking assignments here would create simulation races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      carry_out <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Without a new operand set the previous result is held.
      if (in_valid) begin
        sum       <= WIDTH'(sum_comb);
        carry_out <= carry[EFF_WIDTH];
      end
    end
  end

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Bench for full_adder: WIDTH=1 and WIDTH=8 instances checked against an arithmetic model
// every cycle, plus directed vectors with literal expectations.
module tb_full_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       v1, a1, b1, c1;
  logic       s1, co1, ov1;

  logic       v8, c8;
  logic [7:0] a8, b8;
  logic [7:0] s8;
  logic       co8, ov8;

  int compared   = 0;
  int mismatched = 0;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .carry_in(c1),
    .sum(s1), .carry_out(co1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .carry_in(c8),
    .sum(s8), .carry_out(co8), .out_valid(ov8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: integer addition of the sampled operands, held when idle.
  logic       m1_s, m1_c, m1_v;
  logic [7:0] m8_s;
  logic       m8_c, m8_v;
  int         t1, t8;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1_s <= 1'b0; m1_c <= 1'b0; m1_v <= 1'b0;
      m8_s <= 8'h00; m8_c <= 1'b0; m8_v <= 1'b0;
    end else begin
      m1_v <= v1;
      m8_v <= v8;
      if (v1) begin
        t1 = int'(a1) + int'(b1) + int'(c1);
        m1_s <= t1[0];
        m1_c <= t1[1];
      end
      if (v8) begin
        t8 = int'(a8) + int'(b8) + int'(c8);
        m8_s <= t8[7:0];
        m8_c <= t8[8];
      end
    end
  end

  always @(negedge clk) begin
    check("model_ov1", 64'(ov1), 64'(m1_v));
    check("model_s1",  64'(s1),  64'(m1_s));
    check("model_co1", 64'(co1), 64'(m1_c));
    check("model_ov8", 64'(ov8), 64'(m8_v));
    check("model_s8",  64'(s8),  64'(m8_s));
    check("model_co8", 64'(co8), 64'(m8_c));
  end

  task automatic step1(input logic a, input logic b, input logic c);
    a1 = a; b1 = b; c1 = c; v1 = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic step8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
    a8 = a; b8 = b; c8 = c; v8 = v;
    @(posedge clk); #1;
  endtask

  // {a, b, carry_in, sum, carry_out}
  logic [4:0] vec1 [8] = '{5'b000_00, 5'b001_10, 5'b100_10, 5'b101_01,
                           5'b010_10, 5'b011_01, 5'b110_01, 5'b111_11};

  initial begin
    int n_valid;
    logic [4:0] e;
    rst = 1'b0;
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    v8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_s1",  64'(s1),  64'd0);
    check("reset_co1", 64'(co1), 64'd0);
    check("reset_ov1", 64'(ov1), 64'd0);
    check("reset_s8",  64'(s8),  64'd0);
    check("reset_ov8", 64'(ov8), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // WIDTH=1 exhaustive truth table
    for (int i = 0; i < 8; i++) begin
      e = vec1[i];
      step1(e[4], e[3], e[2]);
      check($sformatf("w1_sum_%0d", i),  64'(s1),  64'(e[1]));
      check($sformatf("w1_cout_%0d", i), 64'(co1), 64'(e[0]));
      check($sformatf("w1_ov_%0d", i),   64'(ov1), 64'd1);
    end

    // Asynchronous reset between edges while sum=1, carry_out=1
    v1 = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_s1",  64'(s1),  64'd0);
    check("async_rst_co1", 64'(co1), 64'd0);
    check("async_rst_ov1", 64'(ov1), 64'd0);
    @(posedge clk); #1;
    check("rst_held_s1", 64'(s1), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_after_rst_s1",  64'(s1),  64'd0);
    check("idle_after_rst_ov1", 64'(ov1), 64'd0);
    step1(1'b1, 1'b0, 1'b0);
    check("post_rst_s1",  64'(s1),  64'd1);
    check("post_rst_ov1", 64'(ov1), 64'd1);
    v1 = 1'b0;

    // WIDTH=8 boundaries
    step8(1'b1, 8'hFF, 8'h01, 1'b0);
    check("wrap_s8", 64'(s8), 64'h00);  check("wrap_co8", 64'(co8), 64'd1);
    step8(1'b1, 8'hFF, 8'hFF, 1'b1);
    check("max_s8", 64'(s8), 64'hFF);   check("max_co8", 64'(co8), 64'd1);
    step8(1'b1, 8'h00, 8'h00, 1'b0);
    check("zero_s8", 64'(s8), 64'h00);  check("zero_co8", 64'(co8), 64'd0);
    step8(1'b1, 8'hFF, 8'h00, 1'b1);
    check("cin_wrap_s8", 64'(s8), 64'h00); check("cin_wrap_co8", 64'(co8), 64'd1);

    // WIDTH=8 streaming: five back-to-back operand sets
    n_valid = 0;
    for (int i = 0; i < 5; i++) begin
      step8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      if (ov8) n_valid++;
    end
    check("stream_valid_count", 64'(n_valid), 64'd5);

    // Hold: 0x12 + 0x34 + 1 = 0x47, then idle with changing operands
    step8(1'b1, 8'h12, 8'h34, 1'b1);
    check("hold_base_s8", 64'(s8), 64'h47);
    for (int i = 0; i < 3; i++) begin
      step8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
      check($sformatf("hold_s8_%0d", i),  64'(s8),  64'h47);
      check($sformatf("hold_co8_%0d", i), 64'(co8), 64'd0);
      check($sformatf("hold_ov8_%0d", i), 64'(ov8), 64'd0);
    end

    // Reset mid-stream discards the in-flight result
    step8(1'b1, 8'h10, 8'h20, 1'b0);
    v8 = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_ov8", 64'(ov8), 64'd0);
    check("midrst_s8",  64'(s8),  64'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    step8(1'b1, 8'h80, 8'h80, 1'b1);
    check("post_midrst_s8",  64'(s8),  64'h01);
    check("post_midrst_co8", 64'(co8), 64'd1);
    check("post_midrst_ov8", 64'(ov8), 64'd1);
    v8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("final_ov8", 64'(ov8), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_full_adder
